reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter SS, default 2, dispatch and commit width in entries per cycle.
REQ-002 Parameter DEPTH, default 16, entry count; SHALL be a power of two and at least 2*SS.
REQ-003 Parameter CDB_PORTS, default 2, number of writeback ports.
REQ-004 Parameter PAYLOAD_W, default 128, opaque dispatch payload width.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 disp_valid  in  [SS]  per-lane dispatch request; lanes SHALL be contiguous from lane 0.
REQ-008 disp_payload  in  [SS][PAYLOAD_W]  per-lane payload.
REQ-009 disp_is_store  in  [SS]  lane carries a store.
REQ-010 disp_ready  out  1  high when free entries >= SS.
REQ-011 disp_rob_id  out  [SS][IDW]  id allocated to lane i (tail+i mod DEPTH); IDW = clog2(DEPTH).
REQ-012 cdb_valid  in  [CDB_PORTS]  writeback strobe.
REQ-013 cdb_rob_id  in  [CDB_PORTS][IDW]  target entry.
REQ-014 cdb_value  in  [CDB_PORTS][32]  result value.
REQ-015 cdb_mispredict  in  [CDB_PORTS]  entry redirects control flow.
REQ-016 commit_valid  out  [SS]  lane i retires this cycle.
REQ-017 commit_payload, commit_value, commit_rob_id  out  [SS][...]  retiring entry contents.
REQ-018 commit_order  out  [SS][64]  retirement sequence number.
REQ-019 commit_store  out  [SS]  lane i retires a store; LSQ releases it.
REQ-020 flush  out  1  mispredict retired; all younger state invalid.
REQ-021 count  out  [IDW+1]  occupied entries.

Function
REQ-022 Pointers head/tail SHALL be IDW+1 bits; full when MSBs differ and low bits match, empty when equal; count = tail-head.
REQ-023 Dispatch SHALL be accepted when disp_ready and disp_valid[0]; tail advances by popcount(disp_valid); new entries done=0, mispredict=0.
REQ-024 Dispatch while !disp_ready SHALL be ignored with no state change.
REQ-025 CDB write SHALL set done=1, store value and mispredict, registered next edge; writes to ids outside [head,tail) SHALL be ignored.
REQ-026 Two CDB ports naming the same id in one cycle: higher port index wins.
REQ-027 commit_valid[i] SHALL be combinational: entry head+i occupied, done, and every older lane j<i committing with mispredict=0 (in-order prefix; partial commit allowed, unlike all-or-nothing).
REQ-028 head SHALL advance by the number of committing lanes at the clock edge.
REQ-029 commit_order[i] SHALL equal order_counter+i; order_counter increments by committed count, 64-bit wrap.
REQ-030 flush SHALL assert in the same cycle a committing lane has mispredict=1; that lane retires, younger lanes do not.
REQ-031 On flush, next edge SHALL set tail=head_new (empty); dispatch and CDB writes that cycle SHALL be dropped; order_counter keeps its increment.
REQ-032 commit_store[i] SHALL equal commit_valid[i] && is_store of that entry, a one-cycle pulse per store.
REQ-033 Simultaneous commit and dispatch with full queue: disp_ready is computed from pre-commit count (no bypass).

Reset
REQ-034 On rst: head=tail=0, all done/mispredict=0, order_counter=0, so disp_ready=1, count=0, commit_valid=0, commit_store=0, flush=0; reset mid-operation discards all entries.

Structure
REQ-035 Parameter defaults, IDW helper and the rob entry struct (payload, value, done, mispredict, is_store) SHALL live in rv32i_types.
REQ-036 Commit-prefix logic SHALL be one sub-module rob_commit_select (inputs head-window done/mispredict/occupied, outputs commit_valid, flush, commit count).

Verification (SS=2, DEPTH=8, CDB_PORTS=2)
REQ-037 Reset, dispatch 2 per cycle x4 -> ids 0..7, count=8, disp_ready=0; 5th dispatch ignored.
REQ-038 CDB completes id1 then id0 -> no commit until id0 done, then both commit same cycle, commit_order 0,1.
REQ-039 Only id0 done of ids 0..3 -> commit_valid=01, head=1; id1 done next -> commit_order=1.
REQ-040 ids 0..5 done, id2 mispredict, head at 2 -> flush=1, id2 retires alone, next cycle count=0, order_counter=+1.
REQ-041 Wrap: 20 dispatch/commit pairs -> ids wrap 7->0, full/empty correct, order reaches 20; store at id3 -> commit_store pulses once.

Source files
------------

// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared reorder buffer defaults, id-width helper and entry layout
package rv32i_types;

  localparam int ROB_SS_DEFAULT        = 2;
  localparam int ROB_DEPTH_DEFAULT     = 16;
  localparam int ROB_CDB_PORTS_DEFAULT = 2;
  localparam int ROB_PAYLOAD_W_DEFAULT = 128;
  // Entries hold the widest payload; narrower configurations use the low bits.
  localparam int ROB_PAYLOAD_MAX_W     = 128;

  function automatic int rob_idw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic [ROB_PAYLOAD_MAX_W-1:0] payload;
    logic [31:0]                  value;
    logic                         done;
    logic                         mispredict;
    logic                         is_store;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// rtl/rob_commit_select.sv - in-order commit prefix over the head window
module rob_commit_select #(
  parameter  int SS = 2,
  localparam int CW = $clog2(SS + 1)
) (
  input  logic [SS-1:0] occupied,
  input  logic [SS-1:0] done,
  input  logic [SS-1:0] mispredict,
  output logic [SS-1:0] commit_valid,
  output logic          flush,
  output logic [CW-1:0] commit_cnt
);

  logic go;

  // A lane retires only if every older lane retired and none of them redirected.
  always_comb begin
    commit_valid = '0;
    flush        = 1'b0;
    commit_cnt   = '0;
    go           = 1'b1;
    for (int i = 0; i < SS; i++) begin
      commit_valid[i] = go & occupied[i] & done[i];
      if (commit_valid[i]) begin
        commit_cnt = commit_cnt + CW'(1);
      end
      flush = flush | (commit_valid[i] & mispredict[i]);
      go    = commit_valid[i] & ~mispredict[i];
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - superscalar reorder buffer with CDB writeback and mispredict flush
module reorder_buffer
  import rv32i_types::*;
#(
  parameter  int SS        = ROB_SS_DEFAULT,
  parameter  int DEPTH     = ROB_DEPTH_DEFAULT,
  parameter  int CDB_PORTS = ROB_CDB_PORTS_DEFAULT,
  parameter  int PAYLOAD_W = ROB_PAYLOAD_W_DEFAULT,
  localparam int IDW       = rob_idw(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SS-1:0]                  disp_valid,
  input  logic [SS-1:0][PAYLOAD_W-1:0]   disp_payload,
  input  logic [SS-1:0]                  disp_is_store,
  output logic                           disp_ready,
  output logic [SS-1:0][IDW-1:0]         disp_rob_id,
  input  logic [CDB_PORTS-1:0]           cdb_valid,
  input  logic [CDB_PORTS-1:0][IDW-1:0]  cdb_rob_id,
  input  logic [CDB_PORTS-1:0][31:0]     cdb_value,
  input  logic [CDB_PORTS-1:0]           cdb_mispredict,
  output logic [SS-1:0]                  commit_valid,
  output logic [SS-1:0][PAYLOAD_W-1:0]   commit_payload,
  output logic [SS-1:0][31:0]            commit_value,
  output logic [SS-1:0][IDW-1:0]         commit_rob_id,
  output logic [SS-1:0][63:0]            commit_order,
  output logic [SS-1:0]                  commit_store,
  output logic                           flush,
  output logic [IDW:0]                   count
);

  localparam int PW = IDW + 1;
  localparam int CW = $clog2(SS + 1);

  rob_entry_t    entries_q [DEPTH];
  rob_entry_t    entries_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [63:0]   order_q, order_d;

  logic [PW-1:0]  free_cnt;
  logic [CW-1:0]  n_disp;
  logic           disp_fire;
  logic [CW-1:0]  commit_cnt;
  logic [SS-1:0]  win_occ, win_done, win_misp;
  logic [IDW-1:0] win_idx [SS];
  logic [IDW-1:0] cdb_off [CDB_PORTS];
  logic [CDB_PORTS-1:0] cdb_in_win;

  // Pointers carry one extra wrap bit, so the subtraction is the occupancy.
  assign count      = tail_q - head_q;
  assign free_cnt   = PW'(DEPTH) - count;
  assign disp_ready = free_cnt >= PW'(SS);
  assign disp_fire  = disp_ready & disp_valid[0] & ~flush;

  always_comb begin
    n_disp = '0;
    for (int i = 0; i < SS; i++) begin
      disp_rob_id[i] = tail_q[IDW-1:0] + IDW'(i);
      if (disp_valid[i]) begin
        n_disp = n_disp + CW'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SS; i++) begin
      win_idx[i]        = head_q[IDW-1:0] + IDW'(i);
      win_occ[i]        = PW'(i) < count;
      win_done[i]       = entries_q[win_idx[i]].done;
      win_misp[i]       = entries_q[win_idx[i]].mispredict;
      commit_rob_id[i]  = win_idx[i];
      commit_payload[i] = entries_q[win_idx[i]].payload[PAYLOAD_W-1:0];
      commit_value[i]   = entries_q[win_idx[i]].value;
      commit_order[i]   = order_q + 64'(i);
      commit_store[i]   = commit_valid[i] & entries_q[win_idx[i]].is_store;
    end
  end

  rob_commit_select #(
    .SS (SS)
  ) u_commit_select (
    .occupied     (win_occ),
    .done         (win_done),
    .mispredict   (win_misp),
    .commit_valid (commit_valid),
    .flush        (flush),
    .commit_cnt   (commit_cnt)
  );

  // Writebacks to ids outside the live window (stale or wrong-path) are dropped.
  always_comb begin
    for (int p = 0; p < CDB_PORTS; p++) begin
      cdb_off[p]    = cdb_rob_id[p] - head_q[IDW-1:0];
      cdb_in_win[p] = {1'b0, cdb_off[p]} < count;
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q + PW'(commit_cnt);
    order_d   = order_q + 64'(commit_cnt);
    tail_d    = tail_q;
    if (flush) begin
      tail_d = head_d;
    end else begin
      // Ascending port order lets the higher port win on a shared id.
      for (int p = 0; p < CDB_PORTS; p++) begin
        if (cdb_valid[p] && cdb_in_win[p]) begin
          entries_d[cdb_rob_id[p]].done       = 1'b1;
          entries_d[cdb_rob_id[p]].value      = cdb_value[p];
          entries_d[cdb_rob_id[p]].mispredict = cdb_mispredict[p];
        end
      end
      if (disp_fire) begin
        for (int i = 0; i < SS; i++) begin
          if (disp_valid[i]) begin
            entries_d[disp_rob_id[i]].payload                = '0;
            entries_d[disp_rob_id[i]].payload[PAYLOAD_W-1:0] = disp_payload[i];
            entries_d[disp_rob_id[i]].value                  = '0;
            entries_d[disp_rob_id[i]].done                   = 1'b0;
            entries_d[disp_rob_id[i]].mispredict             = 1'b0;
            entries_d[disp_rob_id[i]].is_store               = disp_is_store[i];
          end
        end
        tail_d = tail_q + PW'(n_disp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      order_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      order_q   <= order_d;
      entries_q <= entries_d;
    end
  end

endmodule
